// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parameterised UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

    // Wide enough to index every legal data width.
    localparam int BIT_IDX_W = $clog2(DATA_WIDTH_MAX + 1);

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and line sampler for uart_rx_param.
// Build option: define UART_RX_MAJ3_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic               start,
    input  logic               active,
    input  logic [PRESC_W-1:0] prescale,
    output logic               sampled_bit,
    output logic               bit_done
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] last_edge;
    logic [PRESC_W-1:0] half;
    logic               bit_q;

    assign last_edge = prescale - ONE;
    assign half      = prescale >> 1;
    assign bit_done  = active && (edge_cnt == last_edge);

    // The idle cycle that sees the start edge is edge 0, so counting begins there.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (active || start) begin
            edge_cnt <= (edge_cnt == last_edge) ? '0 : edge_cnt + ONE;
        end else begin
            edge_cnt <= '0;
        end
    end

`ifdef UART_RX_MAJ3_EN
    logic [1:0] early;
    logic       maj;
    logic       at_last_sample;

    assign maj            = (early[0] & early[1]) | (early[0] & rx_in) | (early[1] & rx_in);
    assign at_last_sample = edge_cnt == (half + ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            early <= 2'b11;
            bit_q <= 1'b1;
        end else if (active) begin
            if (edge_cnt == (half - ONE)) early[0] <= rx_in;
            if (edge_cnt == half)         early[1] <= rx_in;
            if (at_last_sample)           bit_q    <= maj;
        end
    end

    // With prescale=4 the third sample lands on the bit's last edge, so bypass the flop there.
    assign sampled_bit = at_last_sample ? maj : bit_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_q <= 1'b1;
        end else if (active && (edge_cnt == half)) begin
            bit_q <= rx_in;
        end
    end

    assign sampled_bit = bit_q;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: configurable width, parity, stop bits and oversampling.
// Build option: UART_RX_MAJ3_EN selects majority sampling inside uart_rx_sampler.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_WIDTH - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_ONE  = BIT_IDX_W'(1);

    rx_state_e state, state_nx;

    logic [PRESC_W-1:0]    presc_q;
    logic [PRESC_W-1:0]    presc_eff;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  stop2_q;
    logic [DATA_WIDTH-1:0] data_sr;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic                  par_flag;
    logic                  stop_flag;

    logic start;
    logic active;
    logic sampled_bit;
    logic bit_done;
    logic frame_end;
    logic stop_bad;
    logic par_expected;

    assign start     = (state == IDLE) && !rx_in;
    assign active    = (state != IDLE);
    assign busy      = active;
    // Mid-frame prescale changes must not disturb the frame in progress.
    assign presc_eff = (state == IDLE) ? prescale : presc_q;

    assign stop_bad     = ((state == STOP) || (state == STOP2)) && bit_done && !sampled_bit;
    assign par_expected = (^data_sr) ^ (par_typ_q != PAR_EVEN);

    uart_rx_sampler #(
        .PRESC_W(PRESC_W)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .start      (start),
        .active     (active),
        .prescale   (presc_eff),
        .sampled_bit(sampled_bit),
        .bit_done   (bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        frame_end = 1'b0;
        case (state)
            IDLE:   if (!rx_in) state_nx = START;
            START:  if (bit_done) state_nx = sampled_bit ? IDLE : DATA;
            DATA:   if (bit_done && (bit_idx == LAST_IDX)) state_nx = par_en_q ? PARITY : STOP;
            PARITY: if (bit_done) state_nx = STOP;
            STOP: begin
                if (bit_done) begin
                    if (stop2_q) begin
                        state_nx = STOP2;
                    end else begin
                        state_nx  = IDLE;
                        frame_end = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (bit_done) begin
                    state_nx  = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            data_sr    <= '0;
            bit_idx    <= '0;
            par_flag   <= 1'b0;
            stop_flag  <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_error  <= 1'b0;
            stop_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_error  <= 1'b0;
            stop_error <= 1'b0;

            if (start) begin
                presc_q   <= prescale;
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                stop2_q   <= stop2;
                bit_idx   <= '0;
                par_flag  <= 1'b0;
                stop_flag <= 1'b0;
            end

            // LSB arrives first, so shift in from the top.
            if ((state == DATA) && bit_done) begin
                data_sr <= {sampled_bit, data_sr[DATA_WIDTH-1:1]};
                bit_idx <= bit_idx + IDX_ONE;
            end

            if ((state == PARITY) && bit_done && (sampled_bit != par_expected)) begin
                par_flag <= 1'b1;
            end

            if (stop_bad) begin
                stop_flag <= 1'b1;
            end

            if (frame_end) begin
                par_error  <= par_flag;
                stop_error <= stop_flag | stop_bad;
                if (!(par_flag || stop_flag || stop_bad)) begin
                    data_valid <= 1'b1;
                    p_data     <= data_sr;
                end
            end
        end
    end

endmodule
